// File: rtl/midi_uart_tx_pkg.sv
`timescale 1ns/1ps
// Shared types and MIDI byte-class constants for the MIDI serial transmitter.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] CHAN_MAX   = 8'hEF;
  localparam logic [7:0] SYSCOM_MIN = 8'hF0;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  function automatic logic is_chan_status(input logic [7:0] b);
    return (b >= STATUS_MIN) && (b <= CHAN_MAX);
  endfunction

  function automatic logic is_syscom(input logic [7:0] b);
    return (b >= SYSCOM_MIN) && (b < RT_MIN);
  endfunction

endpackage

// File: rtl/midi_uart_tx_fifo.sv
`timescale 1ns/1ps
// Synchronous byte FIFO with occupancy count, full/empty flags and a
// same-cycle overflow pulse for writes that arrive while full.
module midi_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_i,
  output logic [7:0]    rd_data_o,
  output logic [CW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // A write while full is dropped even if a read frees a slot in the same cycle.
  assign wr_ok   = wr_i & ~full_o;
  assign rd_ok   = rd_i & ~empty_o;
  assign ovf_o   = wr_i & full_o;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign level_o   = count_q;

endmodule

// File: rtl/midi_uart_tx.sv
`timescale 1ns/1ps
// MIDI 8N1 serial transmitter: byte FIFO, baud counter and frame FSM.
// Optional running-status suppression is built when MIDI_RUNNING_STATUS_EN is defined.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter  int CLK_FREQ   = 50000000,
  parameter  int BAUD       = 31250,
  parameter  int FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          data_clk,
  input  logic          reset,
  input  logic          tx_wr,
  input  logic [7:0]    tx_data,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [LW-1:0] tx_level,
  output logic          tx_busy,
  output logic          tx_ovf,
  input  logic          ovf_clr,
  output logic          midi_txd,
  output tx_state_e     dbg_state
);

  localparam int            DIV        = CLK_FREQ / BAUD;
  localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(FRAME_BITS - 3);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q;
  logic          avail_q;

  logic          pop;
  logic          try_pop;
  logic          can_pop;
  logic          cnt_zero;
  logic          drop;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;

  // Push side: tx_wr is a one-cycle strobe with no ready; the producer watches
  // tx_full, and a strobe while full is discarded and flagged in tx_ovf.
  midi_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (data_clk),
    .rst_i     (reset),
    .wr_i      (tx_wr),
    .wr_data_i (tx_data),
    .rd_i      (pop),
    .rd_data_o (head),
    .level_o   (tx_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ovf_o     (fifo_ovf)
  );

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_q;
  logic [7:0] rs_after;

  always_comb begin
    rs_after = rs_q;
    if (is_chan_status(head))  rs_after = head;
    else if (is_syscom(head))  rs_after = '0;
  end

  assign drop = is_chan_status(head) && (head == rs_q);

  always_ff @(posedge data_clk) begin
    if (reset)    rs_q <= '0;
    else if (pop) rs_q <= rs_after;
  end
`else
  assign drop = 1'b0;
`endif

  // The FSM acts on a one-cycle-old view of the FIFO, so a fresh byte is
  // popped two edges after its write; the live flag guards against a stale view.
  assign can_pop  = avail_q & ~fifo_empty;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    try_pop = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: try_pop = 1'b1;
      START: begin
        if (cnt_zero) begin
          cnt_d   = CNT_RELOAD;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_zero) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == LAST_BIT) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_zero) try_pop = 1'b1;
        else          cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Shared launch path for IDLE and the end of a stop bit.
    if (try_pop) begin
      state_d = IDLE;
      if (can_pop) begin
        pop = 1'b1;
        if (!drop) begin
          shift_d = head;
          cnt_d   = CNT_RELOAD;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
    end
  end

  always_ff @(posedge data_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      avail_q <= ~fifo_empty;
    end
  end

  always_ff @(posedge data_clk) begin
    if (reset)         ovf_q <= 1'b0;
    else if (fifo_ovf) ovf_q <= 1'b1;
    else if (ovf_clr)  ovf_q <= 1'b0;
  end

  assign tx_full   = fifo_full;
  assign tx_empty  = fifo_empty;
  assign tx_busy   = (state_q != IDLE) | ~fifo_empty;
  assign tx_ovf    = ovf_q;
  assign midi_txd  = txd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
`timescale 1ns/1ps
// Directed bench for midi_uart_tx at DIV=100; a line monitor decodes frames
// into rx_q for comparison against exp_q.
module tb_midi_uart_tx;
  import midi_pkg::*;

  localparam int DIV = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx_full, tx_empty, tx_busy, tx_ovf, midi_txd;
  logic [4:0] tx_level;
  tx_state_e  dbg_state;

  always #5 clk = ~clk;

  midi_uart_tx #(
    .CLK_FREQ   (3125000),
    .BAUD       (31250),
    .FIFO_DEPTH (16)
  ) dut (
    .data_clk  (clk),
    .reset     (reset),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .tx_level  (tx_level),
    .tx_busy   (tx_busy),
    .tx_ovf    (tx_ovf),
    .ovf_clr   (ovf_clr),
    .midi_txd  (midi_txd),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  logic [7:0] mon_b;
  logic       mon_ok;

  // Samples each bit at its centre; entries are {framing_ok, byte}.
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (midi_txd === 1'b0) begin
        mon_ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (midi_txd !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_b[i] = midi_txd;
        end
        repeat (DIV) @(negedge clk);
        if (midi_txd !== 1'b1) mon_ok = 1'b0;
        rx_q.push_back({mon_ok, mon_b});
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge that samples the write.
  task automatic wr_byte(input logic [7:0] b);
    @(posedge clk); #1;
    tx_wr   = 1'b1;
    tx_data = b;
    @(posedge clk); #1;
    tx_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int i = 0;
    while (tx_busy && i < max_cycles) begin
      tick(1);
      i++;
    end
    n_tests++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: tx_busy still %b after %0d cycles, required 0", tx_busy, max_cycles);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    n_tests++; if (midi_txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd: got %b required 1", midi_txd); end
    n_tests++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b required 1", tx_empty); end
    n_tests++; if (tx_full !== 1'b0)  begin n_fail++; $display("FAIL rst_full: got %b required 0", tx_full); end
    n_tests++; if (tx_level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", tx_level); end
    n_tests++; if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b required 0", tx_busy); end
    n_tests++; if (tx_ovf !== 1'b0)   begin n_fail++; $display("FAIL rst_ovf: got %b required 0", tx_ovf); end
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", dbg_state, IDLE); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'h90, 1'b0};
    rx_q.delete();
    wr_byte(8'h90);
    tick(1);
    n_tests++; if (midi_txd !== 1'b1) begin n_fail++; $display("FAIL single_latency_n1: got %b required 1", midi_txd); end
    tick(1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick(1);
      n_tests++;
      if (midi_txd !== frame[k]) begin
        n_fail++; $display("FAIL single_bit%0d_first: got %b required %b", k, midi_txd, frame[k]);
      end
      tick(DIV - 1);
      n_tests++;
      if (midi_txd !== frame[k]) begin
        n_fail++; $display("FAIL single_bit%0d_last: got %b required %b", k, midi_txd, frame[k]);
      end
    end
    n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_999: got %b required 1", tx_busy); end
    tick(1);
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_1000: got %b required 0", tx_busy); end
    n_tests++; if (midi_txd !== 1'b1) begin n_fail++; $display("FAIL single_idle_txd: got %b required 1", midi_txd); end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h90}) begin
      n_fail++; $display("FAIL single_rx: got %0d frames first %h required 1 frame 190", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h90});
    exp_q.push_back({1'b1, 8'h3C});
    exp_q.push_back({1'b1, 8'h7F});
    @(posedge clk); #1;
    tx_wr = 1'b1; tx_data = 8'h90;
    tick(1);
    n_tests++; if (tx_level !== 5'd1) begin n_fail++; $display("FAIL b2b_level_a: got %0d required 1", tx_level); end
    tx_data = 8'h3C;
    tick(1);
    n_tests++; if (tx_level !== 5'd2) begin n_fail++; $display("FAIL b2b_level_b: got %0d required 2", tx_level); end
    tx_data = 8'h7F;
    tick(1);
    tx_wr = 1'b0;
    n_tests++; if (tx_level !== 5'd2) begin n_fail++; $display("FAIL b2b_level_c: got %0d required 2", tx_level); end
    n_tests++; if (midi_txd !== 1'b0) begin n_fail++; $display("FAIL b2b_start0: got %b required 0", midi_txd); end
    tick(10 * DIV - 1);
    n_tests++; if (midi_txd !== 1'b1) begin n_fail++; $display("FAIL b2b_stop0: got %b required 1", midi_txd); end
    tick(1);
    n_tests++; if (midi_txd !== 1'b0) begin n_fail++; $display("FAIL b2b_start1: got %b required 0", midi_txd); end
    n_tests++; if (tx_level !== 5'd1) begin n_fail++; $display("FAIL b2b_level_pop1: got %0d required 1", tx_level); end
    tick(10 * DIV - 1);
    n_tests++; if (midi_txd !== 1'b1) begin n_fail++; $display("FAIL b2b_stop1: got %b required 1", midi_txd); end
    tick(1);
    n_tests++; if (midi_txd !== 1'b0) begin n_fail++; $display("FAIL b2b_start2: got %b required 0", midi_txd); end
    n_tests++; if (tx_level !== 5'd0) begin n_fail++; $display("FAIL b2b_level_pop2: got %0d required 0", tx_level); end
    tick(10 * DIV - 1);
    n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_2999: got %b required 1", tx_busy); end
    tick(1);
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_3000: got %b required 0", tx_busy); end
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d frames required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_tests++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq [10];
    seq = '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F, 8'hF8, 8'h90, 8'hF0, 8'h90};
    rx_q.delete();
    exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    exp_q.push_back({1'b1, 8'h90});
    exp_q.push_back({1'b1, 8'h3C});
    exp_q.push_back({1'b1, 8'h7F});
    exp_q.push_back({1'b1, 8'h40});
    exp_q.push_back({1'b1, 8'h7F});
    exp_q.push_back({1'b1, 8'hF8});
    exp_q.push_back({1'b1, 8'hF0});
    exp_q.push_back({1'b1, 8'h90});
`else
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, seq[i]});
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      tx_wr = 1'b1; tx_data = seq[i];
      tick(1);
    end
    tx_wr = 1'b0;
    wait_idle(12000);
    tick(5);
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rs_count: got %0d frames required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_tests++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rs_frame%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    wr_byte(8'h11);
    tick(2);
    for (int i = 0; i < 16; i++) begin
      tx_wr = 1'b1; tx_data = 8'(i);
      tick(1);
    end
    tx_wr = 1'b0;
    n_tests++; if (tx_full !== 1'b1)   begin n_fail++; $display("FAIL ovf_full: got %b required 1", tx_full); end
    n_tests++; if (tx_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level16: got %0d required 16", tx_level); end
    n_tests++; if (tx_ovf !== 1'b0)    begin n_fail++; $display("FAIL ovf_pre: got %b required 0", tx_ovf); end
    tx_wr = 1'b1; tx_data = 8'hAA;
    tick(1);
    tx_wr = 1'b0;
    n_tests++; if (tx_ovf !== 1'b1)    begin n_fail++; $display("FAIL ovf_set: got %b required 1", tx_ovf); end
    n_tests++; if (tx_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level_drop: got %0d required 16", tx_level); end
    tick(3);
    n_tests++; if (tx_ovf !== 1'b1)    begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", tx_ovf); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_tests++; if (tx_ovf !== 1'b0)    begin n_fail++; $display("FAIL ovf_clear: got %b required 0", tx_ovf); end
    tx_wr = 1'b1; tx_data = 8'hAB; ovf_clr = 1'b1;
    tick(1);
    tx_wr = 1'b0; ovf_clr = 1'b0;
    n_tests++; if (tx_ovf !== 1'b1)    begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b required 1", tx_ovf); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_tests++; if (tx_level !== 5'd0)  begin n_fail++; $display("FAIL ovf_reset_level: got %0d required 0", tx_level); end
    n_tests++; if (tx_ovf !== 1'b0)    begin n_fail++; $display("FAIL ovf_reset_flag: got %b required 0", tx_ovf); end
    tick(1100);
    rx_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    wr_byte(8'hC3);
    tick(1);
    wr_byte(8'h22);
    tick(449);
    n_tests++; if (dbg_state !== DATA) begin n_fail++; $display("FAIL midrst_state: got %0d required %0d", dbg_state, DATA); end
    n_tests++; if (tx_level !== 5'd1)  begin n_fail++; $display("FAIL midrst_level_pre: got %0d required 1", tx_level); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_tests++; if (midi_txd !== 1'b1)  begin n_fail++; $display("FAIL midrst_txd: got %b required 1", midi_txd); end
    n_tests++; if (tx_level !== 5'd0)  begin n_fail++; $display("FAIL midrst_level: got %0d required 0", tx_level); end
    n_tests++; if (tx_busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy: got %b required 0", tx_busy); end
    n_tests++; if (tx_empty !== 1'b1)  begin n_fail++; $display("FAIL midrst_empty: got %b required 1", tx_empty); end
    tick(1100);
    rx_q.delete();
    wr_byte(8'h55);
    wait_idle(1200);
    tick(2);
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h55}) begin
      n_fail++; $display("FAIL midrst_rx55: got %0d frames first %h required 1 frame 155", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin : main
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_running_status();
    test_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
